// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizing defaults and clear-sequencer state type for the register file
package regfile_pkg;
    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int ADDR_WIDTH_DEFAULT = 5;
    localparam int DEPTH              = 2 ** ADDR_WIDTH_DEFAULT;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } regfileClearState_t;
endpackage

// File: rtl/regfile_clear_sequencer.sv
// rtl/regfile_clear_sequencer.sv - post-reset zero-fill walker over entries 1..DEPTH-1
module regfile_clear_sequencer
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  clearActive,
    output logic [ADDR_WIDTH-1:0] clearIndex
);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'((1 << ADDR_WIDTH) - 1);

    regfileClearState_t    r_state;
    logic                  r_clearActive;
    logic [ADDR_WIDTH-1:0] r_index;

    // Entry 0 is hard-wired, so the walk starts at 1 and stops on the last entry without wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= CLEAR;
            r_clearActive <= 1'b1;
            r_index       <= ADDR_WIDTH'(1);
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_index == LAST_INDEX) begin
                        r_state       <= READY;
                        r_clearActive <= 1'b0;
                    end else begin
                        r_index <= r_index + ADDR_WIDTH'(1);
                    end
                end
                READY: begin
                    r_state       <= READY;
                    r_clearActive <= 1'b0;
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign clearActive = r_clearActive;
    assign clearIndex  = r_index;
endmodule

// File: rtl/regfile_storage_array.sv
// rtl/regfile_storage_array.sv - 2W2R register file built from two 1W banks plus a live-value table
module regfile_storage_array
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  writeEnableAReg,
    input  logic                  writeEnableBReg,
    input  logic [ADDR_WIDTH-1:0] writeAddressAReg,
    input  logic [ADDR_WIDTH-1:0] writeAddressBReg,
    input  logic [ADDR_WIDTH-1:0] readAddressAReg,
    input  logic [ADDR_WIDTH-1:0] readAddressBReg,
    input  logic [DATA_WIDTH-1:0] writeDataA,
    input  logic [DATA_WIDTH-1:0] writeDataB,
    output logic [DATA_WIDTH-1:0] readDataA,
    output logic [DATA_WIDTH-1:0] readDataB,
    output logic                  clearBusy
);
    localparam int BANK_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_bankA [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] r_bankB [BANK_DEPTH];
    logic                  r_lvt   [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] r_readDataA;
    logic [DATA_WIDTH-1:0] r_readDataB;

    logic                  w_clearActive;
    logic [ADDR_WIDTH-1:0] w_clearIndex;
    logic                  w_effA;
    logic                  w_effB;
    logic                  w_bankAWe;
    logic [ADDR_WIDTH-1:0] w_bankAAddr;
    logic [DATA_WIDTH-1:0] w_bankAData;
    logic [DATA_WIDTH-1:0] w_nextA;
    logic [DATA_WIDTH-1:0] w_nextB;

    regfile_clear_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_sequencer (
        .clk         (clk),
        .reset       (reset),
        .clearActive (w_clearActive),
        .clearIndex  (w_clearIndex)
    );

    assign w_effA = writeEnableAReg && (writeAddressAReg != '0) && !w_clearActive;
    assign w_effB = writeEnableBReg && (writeAddressBReg != '0) && !w_clearActive;

    // The zero fill borrows bank A's write port; the LVT entry is pointed back at bank A too.
    assign w_bankAWe   = w_clearActive || w_effA;
    assign w_bankAAddr = w_clearActive ? w_clearIndex : writeAddressAReg;
    assign w_bankAData = w_clearActive ? '0 : writeDataA;

    // LVT update for B comes last so B wins when both ports hit one address.
    always_ff @(posedge clk) begin
        if (w_bankAWe) begin
            r_bankA[w_bankAAddr] <= w_bankAData;
            r_lvt[w_bankAAddr]   <= 1'b0;
        end
        if (w_effB) begin
            r_bankB[writeAddressBReg] <= writeDataB;
            r_lvt[writeAddressBReg]   <= 1'b1;
        end
    end

    always_comb begin
        w_nextA = r_lvt[readAddressAReg] ? r_bankB[readAddressAReg] : r_bankA[readAddressAReg];
        if (w_effA && (writeAddressAReg == readAddressAReg)) w_nextA = writeDataA;
        if (w_effB && (writeAddressBReg == readAddressAReg)) w_nextA = writeDataB;
        if (w_clearActive || (readAddressAReg == '0)) w_nextA = '0;
    end

    always_comb begin
        w_nextB = r_lvt[readAddressBReg] ? r_bankB[readAddressBReg] : r_bankA[readAddressBReg];
        if (w_effA && (writeAddressAReg == readAddressBReg)) w_nextB = writeDataA;
        if (w_effB && (writeAddressBReg == readAddressBReg)) w_nextB = writeDataB;
        if (w_clearActive || (readAddressBReg == '0)) w_nextB = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readDataA <= '0;
            r_readDataB <= '0;
        end else begin
            r_readDataA <= w_nextA;
            r_readDataB <= w_nextB;
        end
    end

    assign readDataA = r_readDataA;
    assign readDataB = r_readDataB;
    assign clearBusy = w_clearActive;
endmodule

// File: tb/tb_regfile_storage_array.sv
// tb/tb_regfile_storage_array.sv - directed self-checking bench for regfile_storage_array
module tb_regfile_storage_array;
    logic        clk;
    logic        reset;
    logic        writeEnableAReg;
    logic        writeEnableBReg;
    logic [4:0]  writeAddressAReg;
    logic [4:0]  writeAddressBReg;
    logic [4:0]  readAddressAReg;
    logic [4:0]  readAddressBReg;
    logic [31:0] writeDataA;
    logic [31:0] writeDataB;
    logic [31:0] readDataA;
    logic [31:0] readDataB;
    logic        clearBusy;

    int n_cmp;
    int n_err;
    int busy_edges;

    regfile_storage_array #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .writeEnableAReg  (writeEnableAReg),
        .writeEnableBReg  (writeEnableBReg),
        .writeAddressAReg (writeAddressAReg),
        .writeAddressBReg (writeAddressBReg),
        .readAddressAReg  (readAddressAReg),
        .readAddressBReg  (readAddressBReg),
        .writeDataA       (writeDataA),
        .writeDataB       (writeDataB),
        .readDataA        (readDataA),
        .readDataB        (readDataB),
        .clearBusy        (clearBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        writeEnableAReg  = 1'b0;
        writeEnableBReg  = 1'b0;
        writeAddressAReg = 5'd0;
        writeAddressBReg = 5'd0;
        writeDataA       = 32'h0;
        writeDataB       = 32'h0;
    endtask

    // Counts edges until clearBusy drops; optionally injects a write that must be dropped on the 10th edge.
    task automatic count_busy(input bit inject);
        busy_edges = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (!clearBusy) begin
                busy_edges = n;
                break;
            end
            if (inject && n == 9) begin
                writeEnableAReg  = 1'b1;
                writeAddressAReg = 5'd3;
                writeDataA       = 32'hABCD0123;
                readAddressAReg  = 5'd3;
            end
            if (inject && n == 10) begin
                chk("read_during_clear", readDataA, 32'h0);
                idle_inputs();
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        readAddressAReg = 5'd0;
        readAddressBReg = 5'd0;
        step();
        step();
        chk("reset_readDataA", readDataA, 32'h0);
        chk("reset_readDataB", readDataB, 32'h0);
        chk("reset_clearBusy", {31'h0, clearBusy}, 32'h1);

        reset = 1'b0;
        count_busy(1'b1);
        chk("clear_edges", busy_edges, 32'd31);

        for (int i = 1; i < 32; i++) begin
            readAddressAReg = 5'(i);
            readAddressBReg = 5'(i);
            step();
            chk($sformatf("cleared_A_%0d", i), readDataA, 32'h0);
            chk($sformatf("cleared_B_%0d", i), readDataB, 32'h0);
        end

        writeEnableAReg  = 1'b1;
        writeAddressAReg = 5'd5;
        writeDataA       = 32'hDEADBEEF;
        readAddressAReg  = 5'd5;
        readAddressBReg  = 5'd6;
        step();
        chk("bypassA_addr5", readDataA, 32'hDEADBEEF);
        chk("other_addr6", readDataB, 32'h0);
        idle_inputs();
        readAddressBReg = 5'd5;
        step();
        chk("arrayB_addr5", readDataB, 32'hDEADBEEF);
        chk("arrayA_addr5", readDataA, 32'hDEADBEEF);

        writeEnableAReg  = 1'b1;
        writeAddressAReg = 5'd9;
        writeDataA       = 32'h11111111;
        writeEnableBReg  = 1'b1;
        writeAddressBReg = 5'd9;
        writeDataB       = 32'h22222222;
        readAddressAReg  = 5'd9;
        readAddressBReg  = 5'd9;
        step();
        chk("bypass_collide_A", readDataA, 32'h22222222);
        chk("bypass_collide_B", readDataB, 32'h22222222);
        idle_inputs();
        step();
        chk("array_collide_A", readDataA, 32'h22222222);
        chk("array_collide_B", readDataB, 32'h22222222);

        writeEnableAReg  = 1'b1;
        writeAddressAReg = 5'd0;
        writeDataA       = 32'hFFFFFFFF;
        writeEnableBReg  = 1'b1;
        writeAddressBReg = 5'd0;
        writeDataB       = 32'h12345678;
        readAddressAReg  = 5'd0;
        readAddressBReg  = 5'd0;
        step();
        chk("zero_bypass_A", readDataA, 32'h0);
        chk("zero_bypass_B", readDataB, 32'h0);
        idle_inputs();
        step();
        chk("zero_later_A", readDataA, 32'h0);
        chk("zero_later_B", readDataB, 32'h0);

        writeEnableBReg  = 1'b1;
        writeAddressBReg = 5'd7;
        writeDataB       = 32'hCAFEF00D;
        readAddressAReg  = 5'd5;
        readAddressBReg  = 5'd3;
        step();
        chk("keep_addr5", readDataA, 32'hDEADBEEF);
        chk("dropped_addr3", readDataB, 32'h0);
        idle_inputs();
        readAddressAReg = 5'd7;
        readAddressBReg = 5'd7;
        step();
        chk("fill_addr7_A", readDataA, 32'hCAFEF00D);
        chk("fill_addr7_B", readDataB, 32'hCAFEF00D);

        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_A", readDataA, 32'h0);
        chk("async_rst_B", readDataB, 32'h0);
        chk("async_rst_busy", {31'h0, clearBusy}, 32'h1);
        step();
        reset = 1'b0;
        count_busy(1'b0);
        chk("reclear_edges", busy_edges, 32'd31);
        step();
        chk("reclear_addr7_A", readDataA, 32'h0);
        chk("reclear_addr7_B", readDataB, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
